// File: rtl/spi_master_ctrl_if.sv
// Host-side handshake and SPI pin bundle for spi_master_ctrl.
// master = controller view, slave = host/peripheral view.
interface spi_master_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             sck;
    logic             cs_n;
    logic             mosi;
    logic             miso;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sck, cs_n, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sck, cs_n, mosi
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: sequences one WIDTH-bit full-duplex transfer per start request,
// owning the load/shift controls of the internal shift register.
module spi_master_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_ctrl_if.master bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] div_cnt, div_cnt_d;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             miso_sample, miso_sample_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_c, en_c, phase_end_c;

    assign phase_end_c = (div_cnt == DIV_W'(CLK_DIV - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            rx_q        <= '0;
            miso_sample <= 1'b0;
            sck_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_d;
            div_cnt     <= div_cnt_d;
            bit_cnt     <= bit_cnt_d;
            shreg       <= shreg_d;
            rx_q        <= rx_d;
            miso_sample <= miso_sample_d;
            sck_q       <= sck_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, phase sequencing and shift-register control
    always_comb begin
        state_d       = state;
        div_cnt_d     = phase_end_c ? '0 : div_cnt + DIV_W'(1);
        bit_cnt_d     = bit_cnt;
        rx_d          = rx_q;
        miso_sample_d = miso_sample;
        sck_d         = sck_q;
        cs_n_d        = cs_n_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        load_c        = 1'b0;
        en_c          = 1'b0;

        case (state)
            S_IDLE: begin
                div_cnt_d = '0;
                cs_n_d    = 1'b1;
                sck_d     = 1'b0;
                busy_d    = 1'b0;
                if (bus.start) begin
                    load_c    = 1'b1;
                    bit_cnt_d = '0;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end_c) begin
                    sck_d         = 1'b1;
                    miso_sample_d = bus.miso;
                    state_d       = S_XFER;
                end
            end
            S_XFER: begin
                if (phase_end_c) begin
                    if (sck_q) begin
                        sck_d     = 1'b0;
                        en_c      = 1'b1;
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end else if (bit_cnt == CNT_W'(WIDTH)) begin
                        // Final low phase completes without another rising edge
                        state_d = S_HOLD;
                    end else begin
                        sck_d         = 1'b1;
                        miso_sample_d = bus.miso;
                    end
                end
            end
            S_HOLD: begin
                if (phase_end_c) begin
                    cs_n_d  = 1'b1;
                    rx_d    = shreg;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                div_cnt_d = '0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Shift register: load has priority over shift
    always_comb begin
        shreg_d = shreg;
        if (load_c) begin
            shreg_d = bus.tx_data;
        end else if (en_c) begin
            shreg_d = {shreg[WIDTH-2:0], miso_sample};
        end
        mosi_d = ~cs_n_d & shreg_d[WIDTH-1];
    end

    assign bus.sck     = sck_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: scenario tasks checked against
// edge-numbered expectations derived from the transfer timing rules.
module tb_spi_master_ctrl;
    localparam int unsigned W = 8;
    localparam int unsigned D = 2;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    spi_master_ctrl_if #(.WIDTH(W)) a_if ();
    spi_master_ctrl_if #(.WIDTH(W)) b_if ();

    spi_master_ctrl #(.WIDTH(W), .CLK_DIV(D)) dut_a (.clk(clk), .rst(rst), .bus(a_if.master));
    spi_master_ctrl #(.WIDTH(W), .CLK_DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

    assign b_if.miso = b_if.mosi;

    always #5 clk = ~clk;

    // Observation record for DUT A, edge-numbered from the accepting edge
    int       n_a;
    int       rise_e[$];
    int       fall_e[$];
    int       done_e[$];
    logic     sent_b[$];
    logic     csn_b[$];
    logic     sck_prev;
    bit       miso_loop;
    logic [W-1:0] miso_pat;

    task automatic clear_a();
        rise_e.delete();
        fall_e.delete();
        done_e.delete();
        sent_b.delete();
        csn_b.delete();
        sck_prev = a_if.sck;
        n_a = -1;
    endtask

    // Advance one edge on DUT A, record pin activity, act as the SPI peripheral
    task automatic step_a();
        int k;
        @(posedge clk);
        #1;
        n_a++;
        if (a_if.sck && !sck_prev) begin
            rise_e.push_back(n_a);
            sent_b.push_back(a_if.mosi);
        end
        if (!a_if.sck && sck_prev) fall_e.push_back(n_a);
        if (a_if.done) done_e.push_back(n_a);
        csn_b.push_back(a_if.cs_n);
        sck_prev = a_if.sck;
        k = rise_e.size() % W;
        a_if.miso = miso_loop ? a_if.mosi : miso_pat[W-1-k];
    endtask

    function automatic logic [W-1:0] word_from(input int first);
        logic [W-1:0] w = '0;
        for (int i = first; i < first + int'(W) && i < sent_b.size(); i++) w = {w[W-2:0], sent_b[i]};
        return w;
    endfunction

    task automatic run_xfer(input string name, input logic [W-1:0] tx, input bit loop, input logic [W-1:0] pat);
        logic [W-1:0] exp_rx;
        int           bad_edges;
        int           tot;
        tot       = int'(D) * (2 * int'(W) + 2) + 1;
        exp_rx    = loop ? tx : pat;
        miso_loop = loop;
        miso_pat  = pat;
        a_if.miso = loop ? a_if.mosi : pat[W-1];
        clear_a();
        a_if.tx_data = tx;
        a_if.start   = 1'b1;
        step_a();
        a_if.start   = 1'b0;
        a_if.tx_data = W'($urandom);
        tests++;
        if (a_if.busy !== 1'b1 || a_if.cs_n !== 1'b0) begin
            fails++;
            $display("FAIL %s accept: busy=%b cs_n=%b required busy=1 cs_n=0", name, a_if.busy, a_if.cs_n);
        end
        for (int i = 1; i <= tot; i++) step_a();
        tests++;
        if (rise_e.size() != int'(W)) begin
            fails++;
            $display("FAIL %s rise_count: got %0d required %0d", name, rise_e.size(), W);
        end
        bad_edges = 0;
        for (int k = 0; k < rise_e.size(); k++) if (rise_e[k] != int'(D) * (1 + 2 * k)) bad_edges++;
        tests++;
        if (bad_edges != 0 || rise_e.size() == 0) begin
            fails++;
            $display("FAIL %s rise_edges: %0d misplaced, first at %0d required %0d", name, bad_edges,
                     (rise_e.size() > 0) ? rise_e[0] : -1, D);
        end
        tests++;
        if (fall_e.size() != int'(W)) begin
            fails++;
            $display("FAIL %s fall_count: got %0d required %0d", name, fall_e.size(), W);
        end
        tests++;
        if (word_from(0) !== tx) begin
            fails++;
            $display("FAIL %s mosi_word: got %h required %h", name, word_from(0), tx);
        end
        tests++;
        if (done_e.size() != 1 || done_e[0] != int'(D) * (2 * int'(W) + 2)) begin
            fails++;
            $display("FAIL %s done: %0d pulses, first at %0d required one at %0d", name, done_e.size(),
                     (done_e.size() > 0) ? done_e[0] : -1, D * (2 * W + 2));
        end
        tests++;
        if (a_if.rx_data !== exp_rx) begin
            fails++;
            $display("FAIL %s rx_data: got %h required %h", name, a_if.rx_data, exp_rx);
        end
        tests++;
        if (a_if.busy !== 1'b0 || a_if.cs_n !== 1'b1) begin
            fails++;
            $display("FAIL %s idle_after: busy=%b cs_n=%b required busy=0 cs_n=1", name, a_if.busy, a_if.cs_n);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        a_if.start = 1'b1;
        a_if.tx_data = 8'hFF;
        a_if.miso = 1'b1;
        b_if.start = 1'b1;
        b_if.tx_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (a_if.sck !== 1'b0 || a_if.cs_n !== 1'b1 || a_if.mosi !== 1'b0 || a_if.busy !== 1'b0 ||
                a_if.done !== 1'b0 || a_if.rx_data !== '0 || b_if.cs_n !== 1'b1 || b_if.busy !== 1'b0)
                bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_values: %0d bad cycles, sck=%b cs_n=%b mosi=%b busy=%b done=%b rx=%h required 0,1,0,0,0,00",
                     bad, a_if.sck, a_if.cs_n, a_if.mosi, a_if.busy, a_if.done, a_if.rx_data);
        end
        rst = 1'b0;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (a_if.busy !== 1'b0 || a_if.cs_n !== 1'b1) begin
            fails++;
            $display("FAIL reset_no_start: busy=%b cs_n=%b required busy=0 cs_n=1", a_if.busy, a_if.cs_n);
        end
    endtask

    task automatic test_loopback();
        run_xfer("loopback_a5", 8'hA5, 1'b1, 8'h00);
    endtask

    task automatic test_constant();
        run_xfer("const_01", 8'h01, 1'b0, 8'hFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) run_xfer("random", W'($urandom), 1'b0, W'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] tx0;
        tx0 = W'($urandom);
        miso_loop = 1'b1;
        a_if.miso = a_if.mosi;
        clear_a();
        a_if.tx_data = tx0;
        a_if.start = 1'b1;
        for (int i = 0; i <= 75; i++) begin
            step_a();
            if (n_a == 10) a_if.tx_data = 8'h3C;
            if (n_a == 36) a_if.tx_data = 8'hC3;
            if (n_a == 74) a_if.start = 1'b0;
        end
        tests++;
        if (rise_e.size() != 2 * int'(W)) begin
            fails++;
            $display("FAIL b2b_rises: got %0d required %0d", rise_e.size(), 2 * W);
        end
        tests++;
        if (word_from(0) !== tx0) begin
            fails++;
            $display("FAIL b2b_first_word: got %h required %h", word_from(0), tx0);
        end
        tests++;
        if (word_from(int'(W)) !== 8'hC3) begin
            fails++;
            $display("FAIL b2b_second_word: got %h required c3", word_from(int'(W)));
        end
        tests++;
        if (csn_b[35] !== 1'b0 || csn_b[36] !== 1'b1 || csn_b[37] !== 1'b1 || csn_b[38] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_cs_gap: cs_n[35..38]=%b%b%b%b required 0110", csn_b[35], csn_b[36], csn_b[37], csn_b[38]);
        end
        tests++;
        if (done_e.size() != 2 || done_e[0] != 36 || done_e[1] != 74) begin
            fails++;
            $display("FAIL b2b_done: %0d pulses first=%0d required 2 at 36,74", done_e.size(),
                     (done_e.size() > 0) ? done_e[0] : -1);
        end
        tests++;
        if (a_if.rx_data !== 8'hC3 || a_if.busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: rx=%h busy=%b required rx=c3 busy=0", a_if.rx_data, a_if.busy);
        end
    endtask

    task automatic test_abort();
        miso_loop = 1'b1;
        a_if.miso = a_if.mosi;
        clear_a();
        a_if.tx_data = W'($urandom);
        a_if.start = 1'b1;
        step_a();
        a_if.start = 1'b0;
        for (int i = 1; i < 15; i++) step_a();
        rst = 1'b1;
        step_a();
        rst = 1'b0;
        tests++;
        if (a_if.cs_n !== 1'b1 || a_if.sck !== 1'b0 || a_if.busy !== 1'b0 || a_if.mosi !== 1'b0 ||
            a_if.rx_data !== '0) begin
            fails++;
            $display("FAIL abort_state: cs_n=%b sck=%b busy=%b mosi=%b rx=%h required 1,0,0,0,00",
                     a_if.cs_n, a_if.sck, a_if.busy, a_if.mosi, a_if.rx_data);
        end
        for (int i = 0; i < 40; i++) step_a();
        tests++;
        if (done_e.size() != 0 || a_if.rx_data !== '0) begin
            fails++;
            $display("FAIL abort_no_done: %0d done pulses rx=%h required 0 pulses rx=00", done_e.size(), a_if.rx_data);
        end
        run_xfer("abort_follow_5a", 8'h5A, 1'b1, 8'h00);
    endtask

    task automatic test_clkdiv1();
        int bad_sck = 0;
        int dones = 0;
        int done_at = -1;
        b_if.tx_data = 8'hF0;
        b_if.start = 1'b1;
        @(posedge clk);
        #1;
        b_if.start = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            @(posedge clk);
            #1;
            if (n <= 16 && b_if.sck !== logic'(n % 2)) bad_sck++;
            if (n > 16 && b_if.sck !== 1'b0) bad_sck++;
            if (b_if.done === 1'b1) begin
                dones++;
                done_at = n;
            end
        end
        tests++;
        if (bad_sck != 0) begin
            fails++;
            $display("FAIL div1_sck: %0d cycles with wrong sck, required toggle every cycle", bad_sck);
        end
        tests++;
        if (dones != 1 || done_at != 18) begin
            fails++;
            $display("FAIL div1_done: %0d pulses last at %0d required one at 18", dones, done_at);
        end
        tests++;
        if (b_if.rx_data !== 8'hF0 || b_if.busy !== 1'b0) begin
            fails++;
            $display("FAIL div1_rx: rx=%h busy=%b required rx=f0 busy=0", b_if.rx_data, b_if.busy);
        end
    endtask

    initial begin
        miso_loop = 1'b0;
        miso_pat = '0;
        test_reset();
        test_loopback();
        test_constant();
        test_random();
        test_back_to_back();
        test_abort();
        test_clkdiv1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
